axis_frame_source: RTL
======================

Name: axis_frame_source

Overview:
- AXI4-Stream video frame transmitter (master) that generates complete raster frames of synthetic pixels.
- Drives the slave input of pixel-processing blocks such as the contrast stage, replacing hand-driven bench stimulus.
- Usable as an on-chip test pattern source.
- Frame framing follows the pipeline convention: tuser marks start-of-frame, tlast marks end-of-line.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- FRAME_WIDTH, 640, active pixels per line.
- FRAME_HEIGHT, 512, lines per frame.
- LINE_GAP, 4, idle cycles (tvalid low) after each line's tlast beat; 0 allowed.
- FRAME_GAP, 16, idle cycles after each frame's final beat, in place of the line gap; 0 allowed.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; start or continue frame generation.
- pattern_sel  in  2  pattern select; sampled at frame start.
- const_value  in  DATA_WIDTH  pixel value for the constant pattern; sampled at frame start.
- m_axis_tdata  out  DATA_WIDTH  pixel data.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tlast  out  1  last pixel of line.
- m_axis_tuser  out  1  first pixel of frame.
- busy  out  1  high while a frame is in progress, including gaps.
- frame_done  out  1  one-cycle pulse on the cycle the final beat of a frame is accepted.

Behaviour:
- Reset (async assert, sync release): all outputs 0; x=0, y=0; state IDLE.
- Beat transfer occurs when tvalid && tready.

State machine:
- IDLE:
  - busy=0.
  - If enable=1: latch pattern_sel and const_value, go to ACTIVE.
  - tvalid rises in the cycle after the transition (registered outputs).
- ACTIVE:
  - tvalid=1. tdata, tlast and tuser reflect the current x,y.
  - On transfer: x increments.
  - At x=FRAME_WIDTH-1: x wraps to 0, y increments, go to LINE_GAP (or FRAME_GAP when y=FRAME_HEIGHT-1).
  - A zero-length gap returns directly to ACTIVE or to the frame-end decision.
- LINE_GAP: tvalid=0 for LINE_GAP cycles, then ACTIVE.
- FRAME_GAP:
  - tvalid=0 for FRAME_GAP cycles. y resets to 0.
  - Then: if enable=1, relatch the selects and go to ACTIVE; otherwise go to IDLE.

AXI-Stream rules:
- While tvalid=1 and tready=0, tdata, tlast and tuser are held stable.
- tvalid is never withdrawn without a transfer.
- tvalid does not depend combinationally on tready.
- tuser=1 only on beat (x=0, y=0).
- tlast=1 only on x=FRAME_WIDTH-1.

Enable and pattern latching:
- Deasserting enable mid-frame does not truncate: the current frame completes, then the block goes to IDLE.
- Changes to pattern_sel or const_value mid-frame have no effect until the next frame.

Patterns (x, y are the beat's coordinates):
- 0: horizontal ramp, tdata = x mod 2^DATA_WIDTH.
- 1: vertical ramp, tdata = y mod 2^DATA_WIDTH.
- 2: 8x8 checkerboard, tdata = (x[3]^y[3]) ? all-ones : 0.
- 3: constant, tdata = const_value.

Other:
- frame_done pulses in the same cycle as the final transfer; the pulse is registered and visible the following cycle.
- Back-to-back frames with FRAME_GAP=0 keep tvalid high continuously across the frame boundary.
- Counter widths: $clog2 of FRAME_WIDTH, FRAME_HEIGHT and max(LINE_GAP, FRAME_GAP)+1.

Optional Feature:
- Macro: AXIS_FRAME_SOURCE_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reloaded at reset) is added. It advances every cycle.
  - In ACTIVE, a new beat is offered only when LFSR bit 0 = 1, inserting pseudo-random tvalid bubbles.
  - Once tvalid=1, it stays high until transfer.
- Undefined: no LFSR logic; tvalid is continuous in ACTIVE.

Test Plan:
- FRAME_WIDTH=8, FRAME_HEIGHT=4, LINE_GAP=2, FRAME_GAP=3, pattern 0, tready=1, enable pulsed one cycle -> exactly 32 beats with tdata 0..7 repeating. tuser on beat 0 only. tlast on beats 7,15,23,31. 2 idle cycles after each line. frame_done once. Return to IDLE.
- Same config, pattern 3, const_value=8'h5A, tready toggling 1/0 each cycle -> every beat is 8'h5A. Outputs stable during tready=0 (assertion). 32 transfers counted.
- FRAME_WIDTH=16, FRAME_HEIGHT=16, pattern 2 -> tdata=0 at (0,0), 8'hFF at (8,0), 0 at (8,8), 8'hFF at (0,8).
- enable held high, FRAME_GAP=0, LINE_GAP=0, pattern 1 -> two frames streamed with tvalid never low. Second frame's beat 0 has tuser=1 and tdata=0. pattern_sel changed mid-frame takes effect only in frame 2.
- Assert rst_n=0 mid-line (x=3, y=1) -> tvalid, tlast, tuser, busy go to 0 immediately (async). After release with enable=1, the next frame starts at (0,0) with tuser=1.
- With AXIS_FRAME_SOURCE_STALL_EN, 64x4 frame, tready=1 -> tvalid has gaps. Transferred beat sequence is identical to the non-stall run. Total 256 beats.

Source files
------------

// File: rtl/axis_frame_source.sv
// axis_frame_source: AXI4-Stream raster test-pattern generator.
// Emits FRAME_WIDTH x FRAME_HEIGHT frames. tuser marks the first pixel of a
// frame and tlast marks the last pixel of each line. Idle gaps follow each
// line and each frame.
// Optional macro AXIS_FRAME_SOURCE_STALL_EN inserts pseudo-random tvalid
// bubbles, driven by a 16-bit LFSR.
module axis_frame_source #(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 512,
    parameter int LINE_GAP     = 4,
    parameter int FRAME_GAP    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    input  logic [DATA_WIDTH-1:0] const_value,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int XW   = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int YW   = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int MAXG = (LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP;
    localparam int GW   = (MAXG > 0) ? $clog2(MAXG + 1) : 1;

    localparam logic [XW-1:0] X_LAST       = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST       = YW'(FRAME_HEIGHT - 1);
    localparam logic [GW-1:0] G_LINE_LAST  = GW'(LINE_GAP - 1);
    localparam logic [GW-1:0] G_FRAME_LAST = GW'(FRAME_GAP - 1);
    localparam logic          ONE_COL      = (FRAME_WIDTH == 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_LGAP, S_FGAP} state_t;

    state_t                state;
    logic [XW-1:0]         x, x_nxt;
    logic [YW-1:0]         y, y_nxt;
    logic [GW-1:0]         gap;
    logic [1:0]            pat_q;
    logic [DATA_WIDTH-1:0] cval_q;
    logic                  offer;

    assign x_nxt = x + 1'b1;
    assign y_nxt = y + 1'b1;

`ifdef AXIS_FRAME_SOURCE_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR (taps 16,14,13,11), free-running; bit 0 gates new beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign offer = lfsr[0];
`else
    assign offer = 1'b1;
`endif

    function automatic logic [DATA_WIDTH-1:0] pix(input logic [1:0] sel,
                                                  input logic [DATA_WIDTH-1:0] cv,
                                                  input logic [31:0] px,
                                                  input logic [31:0] py);
        case (sel)
            2'd0:    pix = DATA_WIDTH'(px);
            2'd1:    pix = DATA_WIDTH'(py);
            2'd2:    pix = (px[3] ^ py[3]) ? '1 : '0;
            default: pix = cv;
        endcase
    endfunction

    // Frame FSM: coordinates, gap timing, and registered stream outputs.
    // Each beat's outputs are loaded on the edge that moves to it, so
    // they stay stable while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            x             <= '0;
            y             <= '0;
            gap           <= '0;
            pat_q         <= '0;
            cval_q        <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy          <= 1'b0;
                    m_axis_tvalid <= 1'b0;
                    if (enable) begin
                        state         <= S_ACTIVE;
                        busy          <= 1'b1;
                        pat_q         <= pattern_sel;
                        cval_q        <= const_value;
                        x             <= '0;
                        y             <= '0;
                        m_axis_tvalid <= offer;
                        m_axis_tdata  <= pix(pattern_sel, const_value, 32'd0, 32'd0);
                        m_axis_tuser  <= 1'b1;
                        m_axis_tlast  <= ONE_COL;
                    end
                end
                S_ACTIVE: begin
                    if (!m_axis_tvalid) begin
                        // beat already loaded; only waiting for the stall gate
                        m_axis_tvalid <= offer;
                    end else if (m_axis_tready) begin
                        if (x == X_LAST) begin
                            x <= '0;
                            if (y == Y_LAST) begin
                                frame_done <= 1'b1;
                                y          <= '0;
                                if (FRAME_GAP != 0) begin
                                    state         <= S_FGAP;
                                    gap           <= '0;
                                    m_axis_tvalid <= 1'b0;
                                    m_axis_tlast  <= 1'b0;
                                end else if (enable) begin
                                    pat_q         <= pattern_sel;
                                    cval_q        <= const_value;
                                    m_axis_tvalid <= offer;
                                    m_axis_tdata  <= pix(pattern_sel, const_value, 32'd0, 32'd0);
                                    m_axis_tuser  <= 1'b1;
                                    m_axis_tlast  <= ONE_COL;
                                end else begin
                                    state         <= S_IDLE;
                                    busy          <= 1'b0;
                                    m_axis_tvalid <= 1'b0;
                                    m_axis_tlast  <= 1'b0;
                                    m_axis_tuser  <= 1'b0;
                                end
                            end else begin
                                y <= y_nxt;
                                if (LINE_GAP != 0) begin
                                    state         <= S_LGAP;
                                    gap           <= '0;
                                    m_axis_tvalid <= 1'b0;
                                    m_axis_tlast  <= 1'b0;
                                end else begin
                                    m_axis_tvalid <= offer;
                                    m_axis_tdata  <= pix(pat_q, cval_q, 32'd0, 32'(y_nxt));
                                    m_axis_tuser  <= 1'b0;
                                    m_axis_tlast  <= ONE_COL;
                                end
                            end
                        end else begin
                            x             <= x_nxt;
                            m_axis_tvalid <= offer;
                            m_axis_tdata  <= pix(pat_q, cval_q, 32'(x_nxt), 32'(y));
                            m_axis_tuser  <= 1'b0;
                            m_axis_tlast  <= (x_nxt == X_LAST);
                        end
                    end
                end
                S_LGAP: begin
                    if (gap == G_LINE_LAST) begin
                        state         <= S_ACTIVE;
                        m_axis_tvalid <= offer;
                        m_axis_tdata  <= pix(pat_q, cval_q, 32'd0, 32'(y));
                        m_axis_tuser  <= 1'b0;
                        m_axis_tlast  <= ONE_COL;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
                default: begin // S_FGAP
                    if (gap == G_FRAME_LAST) begin
                        if (enable) begin
                            state         <= S_ACTIVE;
                            pat_q         <= pattern_sel;
                            cval_q        <= const_value;
                            m_axis_tvalid <= offer;
                            m_axis_tdata  <= pix(pattern_sel, const_value, 32'd0, 32'd0);
                            m_axis_tuser  <= 1'b1;
                            m_axis_tlast  <= ONE_COL;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
